// File: rtl/pulse_freq_meter.sv
// Gated frequency counter.
// Counts rising edges of an asynchronous pulse over a programmable gate
// window and, at each window end, publishes the count, a saturation flag
// and a three-way proximity classification against a target count.
//
// Handshake: result_valid is a one-cycle strobe with no back-pressure. When
// it is high, result/saturated/in_band/above/below carry the just-closed
// window. Between strobes those outputs hold their values; reset clears them.
module pulse_freq_meter #(
    parameter int CNT_W  = 12,
    parameter int GATE_W = 24,
    parameter int CFG_W  = 2,
    parameter int GATE0  = 1000,
    parameter int GATE1  = 2000,
    parameter int GATE2  = 4000,
    parameter int GATE3  = 8000,
    parameter int TOL    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CFG_W-1:0] cfg_sel,
    input  logic             pulse_in,
    input  logic [CNT_W-1:0] target,
    output logic [CNT_W-1:0] result,
    output logic             result_valid,
    output logic             saturated,
    output logic             in_band,
    output logic             above,
    output logic             below
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    // One extra bit so target+TOL and count+TOL cannot wrap.
    localparam logic [CNT_W:0]   TOL_X   = (CNT_W+1)'(TOL);

    // Last gate-counter value of a window for a given select. Selects past
    // the four defined entries reuse the longest gate.
    function automatic logic [GATE_W-1:0] gate_last(input logic [CFG_W-1:0] sel);
        logic [GATE_W-1:0] val;
        int                idx;
        idx = int'(sel);
        case (idx)
            0:       val = GATE_W'(GATE0 - 1);
            1:       val = GATE_W'(GATE1 - 1);
            2:       val = GATE_W'(GATE2 - 1);
            default: val = GATE_W'(GATE3 - 1);
        endcase
        return val;
    endfunction

    state_t             state;
    state_t             state_next;

    logic               s1;
    logic               s2;
    logic               s3;
    logic               edge_det;

    logic [CFG_W-1:0]   cfg_q;
    logic               cfg_chg;

    logic [GATE_W-1:0]  gcnt;
    logic [CNT_W-1:0]   ecnt;
    logic [CNT_W-1:0]   ecnt_next;
    logic               at_end;

    logic               clr_cnt;
    logic               run_cnt;
    logic               win_end;

    logic [CNT_W:0]     fin_x;
    logic [CNT_W:0]     tgt_x;
    logic               above_c;
    logic               below_c;
    logic               in_band_c;

    // Two-flop synchroniser plus one delay flop for rising-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= pulse_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign edge_det = s2 & ~s3;

    // Registered gate select; a difference against the live input is a change.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_q <= '0;
        end else begin
            cfg_q <= cfg_sel;
        end
    end

    assign cfg_chg = (cfg_sel != cfg_q);
    assign at_end  = (gcnt == gate_last(cfg_q));

    // Count including this cycle's edge, pinned at the maximum instead of wrapping.
    assign ecnt_next = (edge_det && (ecnt != CNT_MAX)) ? ecnt + CNT_W'(1) : ecnt;

    // Proximity compare of the closing count against the live target.
    assign fin_x     = {1'b0, ecnt_next};
    assign tgt_x     = {1'b0, target};
    assign above_c   = fin_x > (tgt_x + TOL_X);
    assign below_c   = (fin_x + TOL_X) < tgt_x;
    assign in_band_c = ~above_c & ~below_c;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and counter control. Priority in COUNT: en low, then a
    // select change, then window end, then plain counting.
    always_comb begin
        state_next = state;
        clr_cnt    = 1'b0;
        run_cnt    = 1'b0;
        win_end    = 1'b0;
        case (state)
            IDLE: begin
                clr_cnt = 1'b1;
                if (en) begin
                    state_next = COUNT;
                end
            end
            COUNT: begin
                if (!en) begin
                    state_next = IDLE;
                    clr_cnt    = 1'b1;
                end else if (cfg_chg) begin
                    clr_cnt = 1'b1;
                end else if (at_end) begin
                    win_end = 1'b1;
                    clr_cnt = 1'b1;
                end else begin
                    run_cnt = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                clr_cnt    = 1'b1;
            end
        endcase
    end

    // Gate and edge counters; clearing makes the next window start at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            gcnt <= '0;
            ecnt <= '0;
        end else if (clr_cnt) begin
            gcnt <= '0;
            ecnt <= '0;
        end else if (run_cnt) begin
            gcnt <= gcnt + GATE_W'(1);
            ecnt <= ecnt_next;
        end
    end

    // Published results: updated only on a window end, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            result       <= '0;
            result_valid <= 1'b0;
            saturated    <= 1'b0;
            in_band      <= 1'b0;
            above        <= 1'b0;
            below        <= 1'b0;
        end else begin
            result_valid <= win_end;
            if (win_end) begin
                result    <= ecnt_next;
                saturated <= (ecnt_next == CNT_MAX);
                in_band   <= in_band_c;
                above     <= above_c;
                below     <= below_c;
            end
        end
    end

endmodule

// File: tb/tb_pulse_freq_meter.sv
// Bench for pulse_freq_meter: a 12-bit instance and a 4-bit instance share
// all stimulus. A reference model tracks windows in absolute cycle numbers
// and counts recorded edge times with plain arithmetic.
module tb_pulse_freq_meter;

    localparam int TOL   = 2;
    localparam int GATE0 = 1000;
    localparam int GATE1 = 2000;
    localparam int GATE2 = 4000;
    localparam int GATE3 = 8000;
    localparam int MAX_M = 4095;
    localparam int MAX_S = 15;
    localparam int LIMIT = 9000;

    typedef struct {
        int res;
        bit sat;
        bit ib;
        bit ab;
        bit be;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [1:0]  cfg_sel = 2'd0;
    logic        pulse_in = 1'b0;
    logic [11:0] target = 12'd100;

    logic [11:0] result_m;
    logic        result_valid_m, saturated_m, in_band_m, above_m, below_m;
    logic [3:0]  result_s;
    logic        result_valid_s, saturated_s, in_band_s, above_s, below_s;

    exp_t q_main[$];
    exp_t q_small[$];
    exp_t last_m, last_s;

    int n_cmp = 0;
    int n_fail = 0;

    pulse_freq_meter dut_m (
        .clk(clk), .rst(rst), .en(en), .cfg_sel(cfg_sel), .pulse_in(pulse_in),
        .target(target), .result(result_m), .result_valid(result_valid_m),
        .saturated(saturated_m), .in_band(in_band_m), .above(above_m), .below(below_m)
    );

    pulse_freq_meter #(.CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .en(en), .cfg_sel(cfg_sel), .pulse_in(pulse_in),
        .target(target[3:0]), .result(result_s), .result_valid(result_valid_s),
        .saturated(saturated_s), .in_band(in_band_s), .above(above_s), .below(below_s)
    );

    // Clock.
    always #5 clk = ~clk;

    // Pulse source: manual level, fixed period, or random bits.
    int pmode = 0;
    int per = 10;
    int pph = 0;
    bit pulse_man = 1'b0;
    always @(negedge clk) begin
        case (pmode)
            1: begin
                pulse_in = (pph < per / 2) ? 1'b1 : 1'b0;
                pph = (pph + 1) % per;
            end
            2: pulse_in = 1'($urandom_range(0, 1));
            default: pulse_in = pulse_man;
        endcase
    end

    function automatic int gate_of(input logic [1:0] c);
        case (c)
            2'd0: return GATE0;
            2'd1: return GATE1;
            2'd2: return GATE2;
            default: return GATE3;
        endcase
    endfunction

    function automatic exp_t expect_for(input int raw, input int tgt, input int maxv);
        exp_t e;
        e.res = (raw > maxv) ? maxv : raw;
        e.sat = (e.res == maxv);
        e.ab  = (e.res > tgt + TOL);
        e.be  = (e.res + TOL < tgt);
        e.ib  = !e.ab && !e.be;
        return e;
    endfunction

    function automatic exp_t zero_exp();
        exp_t e;
        e.res = 0; e.sat = 0; e.ib = 0; e.ab = 0; e.be = 0;
        return e;
    endfunction

    // Reference model state: cycle n is the interval after posedge n.
    int   cyc = 0;
    int   wstart = 0;
    int   wlen = 0;
    bit   act = 1'b0;
    bit   p_prev = 1'b0;
    bit   rst_taken = 1'b1;
    logic [1:0] cfg_prev = 2'd0;
    int   edge_q[$];

    task automatic close_window(input int a, input int b);
        int raw;
        int keep[$];
        raw = 0;
        foreach (edge_q[i]) begin
            if (edge_q[i] >= a && edge_q[i] <= b) raw++;
            else if (edge_q[i] > b) keep.push_back(edge_q[i]);
        end
        edge_q = keep;
        q_main.push_back(expect_for(raw, int'(target), MAX_M));
        q_small.push_back(expect_for(raw, int'(target[3:0]), MAX_S));
    endtask

    // Model: a pulse first seen high at posedge n is an edge in cycle n+1;
    // a window opened at posedge w covers cycles w .. w+len-1.
    always @(posedge clk) begin
        cyc++;
        rst_taken = rst;
        if (rst) begin
            act = 1'b0;
            p_prev = 1'b0;
            edge_q.delete();
        end else begin
            if (pulse_in && !p_prev) edge_q.push_back(cyc + 1);
            p_prev = pulse_in;
            if (act) begin
                if (!en) begin
                    act = 1'b0;
                end else if (cfg_sel != cfg_prev) begin
                    wstart = cyc;
                    wlen = gate_of(cfg_sel);
                end else if (cyc - wstart == wlen) begin
                    close_window(wstart, cyc - 1);
                    wstart = cyc;
                end
            end else if (en) begin
                act = 1'b1;
                wstart = cyc;
                wlen = gate_of(cfg_sel);
            end
        end
        cfg_prev = cfg_sel;
    end

    task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        n_cmp++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act_v, exp_v, $time);
        end
    endtask

    task automatic cmp_outputs(input string tag, input logic [11:0] res, input logic sat,
                               input logic ib, input logic ab, input logic be, input exp_t e);
        check({tag, "_result"}, 32'(res), e.res);
        check({tag, "_saturated"}, 32'(sat), 32'(e.sat));
        check({tag, "_in_band"}, 32'(ib), 32'(e.ib));
        check({tag, "_above"}, 32'(ab), 32'(e.ab));
        check({tag, "_below"}, 32'(be), 32'(e.be));
    endtask

    // Scoreboard monitor: strobe must appear exactly when the model closed a
    // window; outputs must equal the latest expectation every cycle.
    always @(negedge clk) begin
        if (rst_taken) begin
            last_m = zero_exp();
            last_s = zero_exp();
        end
        check("m_strobe", 32'(result_valid_m), (q_main.size() > 0) ? 32'd1 : 32'd0);
        if (q_main.size() > 0) last_m = q_main.pop_front();
        cmp_outputs("m", result_m, saturated_m, in_band_m, above_m, below_m, last_m);
        check("s_strobe", 32'(result_valid_s), (q_small.size() > 0) ? 32'd1 : 32'd0);
        if (q_small.size() > 0) last_s = q_small.pop_front();
        cmp_outputs("s", 12'(result_s), saturated_s, in_band_s, above_s, below_s, last_s);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns the number of negedges up to and including the strobe cycle.
    task automatic wait_strobe(output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (result_valid_m !== 1'b1 && k < LIMIT);
        if (result_valid_m !== 1'b1) check("strobe_timeout", 32'(result_valid_m), 32'd1);
    endtask

    // Watchdog.
    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: run did not complete, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    // Driver.
    initial begin
        int k;
        rst = 1'b1; en = 1'b0; cfg_sel = 2'd0; target = 12'd100;
        tick(5);
        rst = 1'b0;
        tick(3);

        // Period 10, 1000-clock gate.
        pmode = 1; per = 10; en = 1'b1;
        wait_strobe(k);
        wait_strobe(k);
        check("win2_count", 32'(result_m), 32'd100);

        // Period 20, 2000-clock gate, three targets.
        tick(1); cfg_sel = 2'd1; per = 20;
        wait_strobe(k);
        wait_strobe(k);
        check("p20_count", 32'(result_m), 32'd100);
        check("p20_in_band", 32'(in_band_m), 32'd1);
        check("p20_above", 32'(above_m), 32'd0);
        check("p20_below", 32'(below_m), 32'd0);
        tick(1); target = 12'd90;
        wait_strobe(k);
        check("t90_above", 32'(above_m), 32'd1);
        check("t90_in_band", 32'(in_band_m), 32'd0);
        tick(1); target = 12'd110;
        wait_strobe(k);
        check("t110_below", 32'(below_m), 32'd1);
        check("t110_above", 32'(above_m), 32'd0);

        // Period 4: the 4-bit instance must pin at 15.
        tick(1); cfg_sel = 2'd0; per = 4;
        wait_strobe(k);
        wait_strobe(k);
        check("sat_small_result", 32'(result_s), 32'd15);
        check("sat_small_flag", 32'(saturated_s), 32'd1);
        check("sat_main_result", 32'(result_m), 32'd250);
        check("sat_main_flag", 32'(saturated_m), 32'd0);

        // Select change at gate cycle 500 restarts with the 8000-clock gate.
        tick(1); per = 10;
        wait_strobe(k);
        wait_strobe(k);
        tick(500);
        cfg_sel = 2'd3;
        wait_strobe(k);
        check("restart_len", k, GATE3 + 2);
        check("restart_count", 32'(result_m), 32'd800);

        // en low at gate cycle 700 for 50 clocks, then a full window.
        tick(1); cfg_sel = 2'd0;
        wait_strobe(k);
        tick(700);
        en = 1'b0;
        tick(50);
        en = 1'b1;
        wait_strobe(k);
        check("reenable_len", k, GATE0 + 2);
        check("reenable_count", 32'(result_m), 32'd100);

        // Reset in the middle of a window.
        tick(300);
        rst = 1'b1;
        tick(1);
        check("midrst_result", 32'(result_m), 32'd0);
        check("midrst_valid", 32'(result_valid_m), 32'd0);
        check("midrst_flags", {29'd0, in_band_m, above_m, below_m}, 32'd0);
        rst = 1'b0;

        // Random pulses, gates, targets and enable drops.
        pmode = 2;
        for (int i = 0; i < 8; i++) begin
            wait_strobe(k);
            tick(1);
            cfg_sel = 2'($urandom_range(0, 1));
            target = 12'($urandom_range(240, 260) << cfg_sel);
            if ($urandom_range(0, 3) == 0) begin
                en = 1'b0;
                tick(int'($urandom_range(1, 20)));
                en = 1'b1;
            end
        end

        // One edge placed on the window-end cycle.
        wait_strobe(k);
        tick(1); cfg_sel = 2'd0; pmode = 0; pulse_man = 1'b0;
        wait_strobe(k);
        wait_strobe(k);
        tick(997);
        pulse_man = 1'b1;
        wait_strobe(k);
        check("end_edge_count", 32'(result_m), 32'd1);
        tick(1); pulse_man = 1'b0;
        wait_strobe(k);
        check("after_end_edge_count", 32'(result_m), 32'd0);

        tick(5);
        en = 1'b0;
        tick(3);
        check("q_main_drained", q_main.size(), 32'd0);
        check("q_small_drained", q_small.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
